fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have redirect_valid  input  1  branch/jump redirect strobe.
REQ-005 SHALL have redirect_pc  input  32  redirect target address.
REQ-006 SHALL have imem_req  output  1  instruction-memory request valid.
REQ-007 SHALL have imem_addr  output  32  instruction-memory request address.
REQ-008 SHALL have imem_gnt  input  1  request accepted when imem_req=1 and imem_gnt=1.
REQ-009 SHALL have imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
REQ-010 SHALL have imem_rdata  input  32  instruction word.
REQ-011 SHALL have inst_valid  output  1  instruction available to decode.
REQ-012 SHALL have inst  output  32  instruction word.
REQ-013 SHALL have inst_pc  output  32  address of inst.
REQ-014 SHALL have inst_fault  output  1  inst is a misaligned-fetch fault token.
REQ-015 SHALL have inst_ready  input  1  decode accepts when inst_valid=1 and inst_ready=1.

Function
REQ-016 SHALL hold registers pc_q (next fetch address), req_pc_q, drop_q, inst_q, inst_pc_q, fault_q and a 3-state FSM: S_REQ, S_WAIT, S_OUT.
REQ-017 S_REQ: imem_req=1 and imem_addr=pc_q when pc_q[1:0]==2'b00; otherwise imem_req=0.
REQ-018 S_REQ, aligned, imem_gnt=1: req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), go S_WAIT.
REQ-019 S_REQ, misaligned pc_q: no memory request; inst_q<=0, inst_pc_q<=pc_q, fault_q<=1, go S_OUT.
REQ-020 S_WAIT: imem_req=0; on imem_rvalid with drop_q=0: inst_q<=imem_rdata, inst_pc_q<=req_pc_q, fault_q<=0, go S_OUT.
REQ-021 S_WAIT: on imem_rvalid with drop_q=1: discard data, drop_q<=0, go S_REQ.
REQ-022 S_OUT: inst_valid=1, inst=inst_q, inst_pc=inst_pc_q, inst_fault=fault_q; on inst_ready go S_REQ; outputs stable while waiting.
REQ-023 inst_valid SHALL be 0 outside S_OUT.
REQ-024 Minimum latency: grant in cycle N, rvalid in N+1 -> inst_valid in N+2; next imem_req in the cycle after the accept.
REQ-025 redirect_valid (any state) SHALL load pc_q<=redirect_pc, overriding REQ-018 increment.
REQ-026 Redirect in S_REQ with imem_gnt=1 same cycle: request is stale; go S_WAIT with drop_q<=1.
REQ-027 Redirect in S_WAIT: drop_q<=1 unless imem_rvalid same cycle, in which case data discarded and go S_REQ.
REQ-028 Redirect in S_OUT: flush held instruction (takes priority over simultaneous inst_ready), go S_REQ.
REQ-029 At most one memory request SHALL be outstanding.

Reset
REQ-030 On rst: pc_q=RESET_PC, state=S_REQ, drop_q=0, inst_q=0, inst_pc_q=0, fault_q=0, so inst_valid=0, inst_fault=0, imem_req=1, imem_addr=RESET_PC immediately.
REQ-031 rst asserted mid-request SHALL abandon it; the first rvalid after reset release for the abandoned request is the environment's responsibility to suppress.

Verification
REQ-032 Reset, gnt=1, rvalid 1 cycle later with 32'h0000_0013, inst_ready=1 -> inst_valid with inst=32'h0000_0013, inst_pc=0; next imem_addr=4.
REQ-033 inst_ready=0 for 5 cycles in S_OUT -> inst/inst_pc stable, imem_req=0 throughout.
REQ-034 Redirect to 32'h0000_0100 while in S_WAIT -> returning rdata dropped, next imem_addr=32'h0000_0100, no inst_valid for dropped word.
REQ-035 Redirect to 32'h0000_0102 -> no imem_req, inst_valid=1, inst_fault=1, inst=0, inst_pc=32'h0000_0102.
REQ-036 Fetch at 32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
REQ-037 Redirect and inst_ready same cycle in S_OUT -> instruction flushed, next imem_addr=redirect_pc.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff and redirect.
// Handshakes: a transfer happens on a rising clk edge where valid (imem_req / inst_valid) and
// ready (imem_gnt / inst_ready) are both 1; imem_rvalid is an unconditioned one-cycle strobe.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for data, hold word for decode.
// Redirects reload the PC from any state; an in-flight stale response is dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        drop_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        fault_q;
    logic        aligned;

    assign aligned = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= 32'h0;
            drop_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (aligned) begin
                        if (bus.imem_gnt) begin
                            req_pc_q <= pc_q;
                            pc_q     <= pc_q + 32'd4;
                            drop_q   <= bus.redirect_valid;
                            state_q  <= S_WAIT;
                        end
                    end else if (!bus.redirect_valid) begin
                        // A redirect arriving with a misaligned PC supersedes the fault token.
                        inst_q    <= 32'h0;
                        inst_pc_q <= pc_q;
                        fault_q   <= 1'b1;
                        state_q   <= S_OUT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (drop_q || bus.redirect_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            inst_q    <= bus.imem_rdata;
                            inst_pc_q <= req_pc_q;
                            fault_q   <= 1'b0;
                            state_q   <= S_OUT;
                        end
                    end else if (bus.redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.redirect_valid || bus.inst_ready) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
            // Redirect overrides the sequential increment from the grant path above.
            if (bus.redirect_valid) begin
                pc_q <= bus.redirect_pc;
            end
        end
    end

    assign bus.imem_req   = (state_q == S_REQ) && aligned;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = (state_q == S_OUT);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_fault = fault_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected decode words, a monitor pops them.
module tb_fetch_unit;

    logic clk;
    logic rst;
    logic [1:0] dbg_state;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected entry: {fault, pc, inst}
    logic [64:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: decode accepts where valid & ready and no flushing redirect
    always @(negedge clk) begin
        #2;
        if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            logic [64:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %h inst %h, queue empty", bus.inst_pc, bus.inst);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst", bus.inst, e[31:0]);
                chk("sb_pc", bus.inst_pc, e[63:32]);
                chk("sb_fault", {31'h0, bus.inst_fault}, {31'h0, e[64]});
            end
        end
    end

    // driver tasks; every task starts and ends at a falling edge
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int stall);
        chk("req_on", {31'h0, bus.imem_req}, 32'd1);
        chk("req_addr", bus.imem_addr, addr);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        chk("wait_req_off", {31'h0, bus.imem_req}, 32'd0);
        chk("wait_valid_off", {31'h0, bus.inst_valid}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        chk("out_valid", {31'h0, bus.inst_valid}, 32'd1);
        exp_q.push_back({1'b0, addr, data});
        for (int i = 0; i < stall; i++) begin
            chk("stall_inst", bus.inst, data);
            chk("stall_pc", bus.inst_pc, addr);
            chk("stall_req_off", {31'h0, bus.imem_req}, 32'd0);
            @(negedge clk);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.inst_ready     = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'h0, bus.inst_valid}, 32'd0);
        chk("rst_fault", {31'h0, bus.inst_fault}, 32'd0);
        chk("rst_req", {31'h0, bus.imem_req}, 32'd1);
        chk("rst_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // basic fetch, then stalled decode
        fetch_one(32'h0000_0000, 32'h0000_0013, 0);
        fetch_one(32'h0000_0004, 32'h0040_0093, 5);

        // redirect while waiting: returning word dropped
        chk("pre_redir_addr", bus.imem_addr, 32'h0000_0008);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk("drop_valid_off", {31'h0, bus.inst_valid}, 32'd0);
        bus.inst_ready = 1'b0;
        fetch_one(32'h0000_0100, 32'h1234_5678, 0);

        // redirect coincident with grant: stale request dropped
        bus.imem_gnt = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("stale_req_off", {31'h0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hBAD0_0001;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.inst_ready = 1'b0;
        chk("stale_valid_off", {31'h0, bus.inst_valid}, 32'd0);
        fetch_one(32'h0000_0200, 32'h0020_0113, 0);

        // redirect coincident with rvalid in wait
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0300;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hBAD0_0002;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.inst_ready = 1'b0;
        chk("coinc_valid_off", {31'h0, bus.inst_valid}, 32'd0);
        fetch_one(32'h0000_0300, 32'h0030_0193, 0);

        // misaligned redirect produces a fault token
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("mis_req_off", {31'h0, bus.imem_req}, 32'd0);
        @(negedge clk);
        chk("mis_valid", {31'h0, bus.inst_valid}, 32'd1);
        chk("mis_fault", {31'h0, bus.inst_fault}, 32'd1);
        chk("mis_inst", bus.inst, 32'h0);
        chk("mis_pc", bus.inst_pc, 32'h0000_0102);
        chk("mis_out_req_off", {31'h0, bus.imem_req}, 32'd0);
        exp_q.push_back({1'b1, 32'h0000_0102, 32'h0});
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        chk("mis_again_req_off", {31'h0, bus.imem_req}, 32'd0);

        // wrap at top of address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'h0050_0293, 0);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // redirect and ready together in S_OUT: flushed
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hBAD0_0003;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk("flush_valid_on", {31'h0, bus.inst_valid}, 32'd1);
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("flush_valid_off", {31'h0, bus.inst_valid}, 32'd0);
        fetch_one(32'h0000_0400, 32'h0060_0313, 0);

        // asynchronous reset mid-request
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'h0, bus.imem_req}, 32'd1);
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_valid", {31'h0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
